// File: rtl/sdram_arbiter.sv
// Two-port req/ack arbiter in front of a 68K-style SDRAM controller bus.
// Accesses are timed by a cycle counter; periodic idle gaps leave room for auto-refresh.
module sdram_arbiter #(
   parameter int ACCESS_CYCLES    = 16,
   parameter int GAP_CYCLES       = 1,
   parameter int REFRESH_INTERVAL = 750,
   parameter int REFRESH_GAP      = 10
) (
   input  logic        clk100_mhz,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [1:0]  p0_be,
   input  logic [23:0] p0_addr,
   input  logic [15:0] p0_wdata,
   output logic        p0_ack,
   output logic [15:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [1:0]  p1_be,
   input  logic [23:0] p1_addr,
   input  logic [15:0] p1_wdata,
   output logic        p1_ack,
   output logic [15:0] p1_rdata,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic [15:0] mem_dout,
   output logic        mem_asn,
   output logic        mem_udsn,
   output logic        mem_ldsn,
   output logic        mem_rw
);

   localparam logic [15:0] ACC_LAST = 16'(ACCESS_CYCLES - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] REF_LAST = 16'(REFRESH_INTERVAL - 1);
   localparam logic [15:0] RG_LAST  = 16'(REFRESH_GAP - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, REFRESH} state_t;

   state_t      state_q;
   logic [15:0] cnt_q;
   logic [15:0] ref_cnt_q;
   logic [15:0] ref_cnt_d;
   logic        ref_due_q;
   logic        ref_due_d;
   logic        last_q;
   logic        sel_q;
   logic        ack_q [2];
   logic [15:0] rdata_q [2];
   logic [23:0] mem_addr_q;
   logic [15:0] mem_din_q;
   logic        mem_asn_q;
   logic        mem_udsn_q;
   logic        mem_ldsn_q;
   logic        mem_rw_q;

   logic        decide;
   logic        gnt_valid;
   logic        gnt_port;
   logic        sel_we;
   logic [1:0]  sel_be;
   logic [23:0] sel_addr;
   logic [15:0] sel_wdata;

   assign p0_ack   = ack_q[0];
   assign p1_ack   = ack_q[1];
   assign p0_rdata = rdata_q[0];
   assign p1_rdata = rdata_q[1];
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_asn  = mem_asn_q;
   assign mem_udsn = mem_udsn_q;
   assign mem_ldsn = mem_ldsn_q;
   assign mem_rw   = mem_rw_q;

   // Grants happen from IDLE and from the final RECOVER cycle only.
   assign decide    = (state_q == IDLE) || ((state_q == RECOVER) && (cnt_q == GAP_LAST));
   assign gnt_valid = p0_req | p1_req;
   assign gnt_port  = (p0_req & p1_req) ? ~last_q : p1_req;
   assign sel_we    = gnt_port ? p1_we    : p0_we;
   assign sel_be    = gnt_port ? p1_be    : p0_be;
   assign sel_addr  = gnt_port ? p1_addr  : p0_addr;
   assign sel_wdata = gnt_port ? p1_wdata : p0_wdata;

   // Saturating refresh timer; refresh_due stays high until a REFRESH gap is taken.
   assign ref_cnt_d = (ref_cnt_q == REF_LAST) ? ref_cnt_q : ref_cnt_q + 16'd1;
   assign ref_due_d = (ref_cnt_d == REF_LAST);

   always_ff @(posedge clk100_mhz) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ref_cnt_q  <= '0;
         ref_due_q  <= 1'b0;
         last_q     <= 1'b1;
         sel_q      <= 1'b0;
         ack_q[0]   <= 1'b0;
         ack_q[1]   <= 1'b0;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_asn_q  <= 1'b1;
         mem_udsn_q <= 1'b1;
         mem_ldsn_q <= 1'b1;
         mem_rw_q   <= 1'b1;
      end else begin
         ack_q[0]  <= 1'b0;
         ack_q[1]  <= 1'b0;
         ref_cnt_q <= ref_cnt_d;
         ref_due_q <= ref_due_d;
         if (decide) begin
            if (ref_due_q) begin
               state_q   <= REFRESH;
               cnt_q     <= '0;
               ref_cnt_q <= '0;
               ref_due_q <= 1'b0;
            end else if (gnt_valid) begin
               last_q <= gnt_port;
               sel_q  <= gnt_port;
               cnt_q  <= '0;
               if (sel_we && (sel_be == 2'b00)) begin
                  // Nothing to write: acknowledge without touching the bus.
                  ack_q[gnt_port] <= 1'b1;
                  state_q         <= RECOVER;
               end else begin
                  mem_addr_q <= sel_addr;
                  mem_din_q  <= sel_wdata;
                  mem_rw_q   <= ~sel_we;
                  mem_asn_q  <= 1'b0;
                  mem_udsn_q <= sel_we ? ~sel_be[1] : 1'b0;
                  mem_ldsn_q <= sel_we ? ~sel_be[0] : 1'b0;
                  state_q    <= ACCESS;
               end
            end else begin
               state_q <= IDLE;
            end
         end else begin
            case (state_q)
               ACCESS: begin
                  if (cnt_q == ACC_LAST) begin
                     if (mem_rw_q) rdata_q[sel_q] <= mem_dout;
                     ack_q[sel_q] <= 1'b1;
                     mem_asn_q    <= 1'b1;
                     mem_udsn_q   <= 1'b1;
                     mem_ldsn_q   <= 1'b1;
                     mem_rw_q     <= 1'b1;
                     state_q      <= RECOVER;
                     cnt_q        <= '0;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
               RECOVER: cnt_q <= cnt_q + 16'd1;
               REFRESH: begin
                  if (cnt_q == RG_LAST) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule
